fir_coef_loader: RTL and testbench

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_coef_loader.sv | 150 +++++++++++++++
 tb/tb_fir_coef_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// Double-buffered coefficient loader for a symmetric FIR: words stream into a shadow bank,
// which is copied whole into the active bank on a sample-boundary commit.
module fir_coef_loader #(
    parameter int unsigned NUM_COEF = 16,
    parameter int unsigned COEF_W   = 18
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sam_clk_en,
    input  logic                         load_start,
    input  logic                         coef_valid,
    input  logic [COEF_W-1:0]            coef_data,
    output logic                         coef_ready,
    output logic [NUM_COEF*COEF_W-1:0]   coef_bus,
    output logic                         busy,
    output logic                         load_done,
    output logic                         load_abort,
    output logic [7:0]                   commit_cnt
);

    localparam int unsigned IdxW = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam int unsigned BusW = NUM_COEF * COEF_W;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_COEF - 1);

    function automatic int default_word(input int i);
        case (i)
            0:  return -3566;
            2:  return -4114;
            4:  return 4863;
            6:  return 5943;
            8:  return -7641;
            10: return -10698;
            12: return 17829;
            15: return 59411;
            default: return 0;
        endcase
    endfunction

    function automatic logic [BusW-1:0] default_set();
        logic [BusW-1:0] s;
        s = '0;
        for (int i = 0; i < int'(NUM_COEF); i++) begin
            s[i*COEF_W +: COEF_W] = COEF_W'(default_word(i));
        end
        return s;
    endfunction

    localparam logic [BusW-1:0] DefaultSet = default_set();

    typedef enum logic [1:0] {StIdle, StLoad, StWaitCommit} state_e;

    state_e                             state_q, state_d;
    logic [IdxW-1:0]                    idx_q, idx_d;
    logic [NUM_COEF-1:0][COEF_W-1:0]    shadow_q, active_q;
    logic                               wr_en, commit, abort;
    logic [1:0]                         rst_sync_q;
    logic                               rst_n;

    // Assertion is immediate; release waits two clock edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                // A restart wins over a word presented in the same cycle.
                if (load_start) begin
                    idx_d = '0;
                    abort = 1'b1;
                end else if (coef_valid) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        state_d = StWaitCommit;
                        idx_d   = '0;
                    end
                end
            end
            StWaitCommit: begin
                if (sam_clk_en) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end else if (load_start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    abort   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            load_done  <= 1'b0;
            load_abort <= 1'b0;
            commit_cnt <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            load_done  <= commit;
            load_abort <= abort;
            if (commit) begin
                commit_cnt <= commit_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= DefaultSet;
            active_q <= DefaultSet;
        end else begin
            if (wr_en) begin
                shadow_q[idx_q] <= coef_data;
            end
            if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

    assign coef_bus   = active_q;
    assign busy       = (state_q != StIdle);
    assign coef_ready = (state_q == StLoad);

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader; commits are checked by a load_done-driven scoreboard.
module tb_fir_coef_loader;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          reset_n, sam_clk_en, load_start, coef_valid;
    logic [W-1:0]  coef_data;
    logic          coef_ready, busy, load_done, load_abort;
    logic [BW-1:0] coef_bus;
    logic [7:0]    commit_cnt;

    always #5 clk = ~clk;

    fir_coef_loader #(.NUM_COEF(N), .COEF_W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sam_clk_en (sam_clk_en),
        .load_start (load_start),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .coef_bus   (coef_bus),
        .busy       (busy),
        .load_done  (load_done),
        .load_abort (load_abort),
        .commit_cnt (commit_cnt)
    );

    typedef struct {
        logic [BW-1:0] bus;
        logic [7:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int dones_seen = 0;
    int aborts_seen = 0;
    int n_commits = 0;
    int m_idx = 0;
    int def_coef[16] = '{-3566, 0, -4114, 0, 4863, 0, 5943, 0,
                         -7641, 0, -10698, 0, 17829, 0, 0, 59411};
    int sh[16];
    logic [BW-1:0] exp_bus;
    logic [BW-1:0] def_bus;
    logic [7:0]    exp_cnt;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] pack_sh();
        logic [BW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s[i*W +: W] = W'(sh[i]);
        return s;
    endfunction

    function automatic logic [BW-1:0] pack_def();
        logic [BW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s[i*W +: W] = W'(def_coef[i]);
        return s;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        m_idx = 0;
    endtask

    task automatic send(input int v);
        coef_valid = 1'b1;
        coef_data  = W'(v);
        step();
        coef_valid = 1'b0;
        sh[m_idx]  = v;
        m_idx++;
    endtask

    task automatic do_commit(input bit with_start);
        sam_clk_en = 1'b1;
        load_start = with_start;
        exp_cnt    = exp_cnt + 8'd1;
        exp_bus    = pack_sh();
        exp_q.push_back('{bus: exp_bus, cnt: exp_cnt});
        n_commits++;
        step();
        sam_clk_en = 1'b0;
        load_start = 1'b0;
        chk("bus_after_commit", coef_bus, exp_bus);
        chk("idle_after_commit", BW'(busy), '0);
    endtask

    task automatic model_reset();
        sh      = def_coef;
        exp_cnt = 8'd0;
        exp_bus = def_bus;
        m_idx   = 0;
    endtask

    // Scoreboard monitor: every load_done pulse must match the oldest queued commit.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (load_done === 1'b1) begin
                dones_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load_done: got load_done=1 required no pulse");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_bus", coef_bus, mon_e.bus);
                    chk("sb_cnt", BW'(commit_cnt), BW'(mon_e.cnt));
                end
            end
            if (load_abort === 1'b1) aborts_seen++;
        end
    end

    initial begin
        def_bus    = pack_def();
        model_reset();
        reset_n    = 1'b0;
        sam_clk_en = 1'b0;
        load_start = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        repeat (3) step();

        // Reset state
        chk("rst_bus", coef_bus, def_bus);
        chk("rst_b15", BW'(coef_bus[15*W +: W]), BW'(18'd59411));
        chk("rst_b0", BW'(coef_bus[0 +: W]), BW'(18'h3F212));
        chk("rst_busy", BW'(busy), '0);
        chk("rst_ready", BW'(coef_ready), '0);
        chk("rst_cnt", BW'(commit_cnt), '0);
        chk("rst_done", BW'(load_done), '0);
        chk("rst_abort", BW'(load_abort), '0);

        // load_start across the two synchroniser edges is ignored
        reset_n    = 1'b1;
        load_start = 1'b1;
        step();
        step();
        load_start = 1'b0;
        chk("sync_release", BW'(busy), '0);
        sam_clk_en = 1'b1;
        step();
        sam_clk_en = 1'b0;
        chk("sam_in_idle", coef_bus, def_bus);

        // Load 1000..1015, commit five cycles after the last word
        start_load();
        chk("busy_load", BW'(busy), BW'(1'b1));
        chk("ready_load", BW'(coef_ready), BW'(1'b1));
        for (int i = 0; i < 16; i++) send(1000 + i);
        chk("ready_wait", BW'(coef_ready), '0);
        chk("busy_wait", BW'(busy), BW'(1'b1));
        for (int i = 0; i < 5; i++) begin
            chk("bus_hold_wait", coef_bus, exp_bus);
            step();
        end
        do_commit(1'b0);
        chk("cnt_one", BW'(commit_cnt), BW'(8'd1));

        // Stalled load with ignored sam_clk_en pulses, extremes and negatives
        start_load();
        for (int i = 0; i < 16; i++) begin
            send((i == 0) ? -131072 : (i == 15) ? 131071 : ((i % 2) ? -(5000 + i) : 7000 + i));
            if (i < 15) begin
                sam_clk_en = 1'b1;
                step();
                sam_clk_en = 1'b0;
                step();
                chk("bus_hold_stall", coef_bus, exp_bus);
                chk("busy_stall", BW'(busy), BW'(1'b1));
            end
        end
        do_commit(1'b0);

        // Restart after 7 words; the word presented with load_start is dropped
        start_load();
        for (int i = 0; i < 7; i++) send(3000 + i);
        load_start = 1'b1;
        coef_valid = 1'b1;
        coef_data  = W'(9999);
        step();
        load_start = 1'b0;
        coef_valid = 1'b0;
        m_idx      = 0;
        chk("abort_pulse", BW'(load_abort), BW'(1'b1));
        chk("abort_ready", BW'(coef_ready), BW'(1'b1));
        step();
        chk("abort_single", BW'(load_abort), '0);
        for (int i = 0; i < 16; i++) send(4000 + i);
        do_commit(1'b0);

        // WAIT_COMMIT: load_start alone restarts, then load_start with sam_clk_en commits
        start_load();
        for (int i = 0; i < 16; i++) send(5000 + i);
        start_load();
        chk("wc_abort", BW'(load_abort), BW'(1'b1));
        chk("wc_back_to_load", BW'(coef_ready), BW'(1'b1));
        chk("wc_bus_hold", coef_bus, exp_bus);
        for (int i = 0; i < 16; i++) send(6000 + i);
        do_commit(1'b1);
        chk("wc_ready_idle", BW'(coef_ready), '0);

        // Reset mid-LOAD after 10 words
        start_load();
        for (int i = 0; i < 10; i++) send(7000 + i);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_bus", coef_bus, def_bus);
        chk("midrst_busy", BW'(busy), '0);
        chk("midrst_cnt", BW'(commit_cnt), '0);
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();

        // 256 commits wrap commit_cnt back to 0
        for (int k = 0; k < 256; k++) begin
            start_load();
            for (int i = 0; i < 16; i++) send(k * 16 + i);
            do_commit(1'b0);
        end
        chk("cnt_wrap", BW'(commit_cnt), '0);

        repeat (3) step();
        chk("sb_drained", BW'(exp_q.size()), '0);
        chk("done_count", BW'(dones_seen), BW'(n_commits));
        chk("abort_count", BW'(aborts_seen), BW'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
